// File: rtl/pla_activation_pipe_if.sv
// Streaming bus of the PLA activation pipe.
// Input sample side plus result side, one bundle.
interface pla_activation_pipe_if #(
  parameter int DATA_W = 32,
  parameter int TAG_W  = 8
);
  logic                     in_valid;
  logic                     in_ready;
  logic signed [DATA_W-1:0] in_x;
  logic                     in_mode;
  logic [TAG_W-1:0]         in_tag;
  logic                     out_valid;
  logic                     out_ready;
  logic signed [DATA_W-1:0] out_y;
  logic [TAG_W-1:0]         out_tag;
  logic                     out_sat;

  modport master (
    output in_valid, in_x, in_mode, in_tag,
    output out_ready,
    input  in_ready,
    input  out_valid, out_y, out_tag, out_sat
  );

  modport slave (
    input  in_valid, in_x, in_mode, in_tag,
    input  out_ready,
    output in_ready,
    output out_valid, out_y, out_tag, out_sat
  );
endinterface

// File: rtl/pla_activation_pipe.sv
// 3-stage piecewise-linear sigmoid/tanh unit.
// Q(DATA_W-FRAC_W).FRAC_W in and out, tag sideband.
module pla_activation_pipe #(
  parameter int DATA_W = 32,
  parameter int FRAC_W = 24,
  parameter int TAG_W  = 8
) (
  input logic clk,
  input logic reset,
  pla_activation_pipe_if.slave bus
);
  localparam int  W  = DATA_W + 2;
  localparam real SC = 2.0 ** FRAC_W;

  localparam logic signed [W-1:0] ONE =
    W'(longint'(SC));
  localparam logic signed [W-1:0] MAXP =
    W'((longint'(1) <<< (DATA_W - 1)) - longint'(1));

  localparam logic signed [W-1:0] TH [1:8] = '{
    W'(longint'(1.065 * SC)),
    W'(longint'(2.164 * SC)),
    W'(longint'(2.977 * SC)),
    W'(longint'(3.724 * SC)),
    W'(longint'(4.442 * SC)),
    W'(longint'(5.147 * SC)),
    W'(longint'(5.846 * SC)),
    W'(longint'(7.236 * SC))
  };

  localparam logic signed [W-1:0] BS [1:8] = '{
    W'(longint'(0.5        * SC)),
    W'(longint'(0.6328125  * SC)),
    W'(longint'(0.765625   * SC)),
    W'(longint'(0.859375   * SC)),
    W'(longint'(0.91796875 * SC)),
    W'(longint'(0.953125   * SC)),
    W'(longint'(0.97265625 * SC)),
    W'(longint'(0.984375   * SC))
  };

  typedef struct packed {
    logic                v;
    logic signed [W-1:0] a;
    logic                neg;
    logic                mode;
    logic [TAG_W-1:0]    tag;
  } s1_t;

  typedef struct packed {
    logic                v;
    logic signed [W-1:0] p;
    logic signed [W-1:0] b;
    logic                sat;
    logic                neg;
    logic                mode;
    logic [TAG_W-1:0]    tag;
  } s2_t;

  s1_t s1;
  s2_t s2;

  logic advance;
  assign advance      = bus.out_ready || !bus.out_valid;
  assign bus.in_ready = advance;

  logic signed [W-1:0] xe;
  logic signed [W-1:0] ax;
  logic signed [W-1:0] a_n;

  // magnitude, tanh pre-doubling, clamp to max positive
  always_comb begin
    xe = W'(bus.in_x);
    ax = xe[W-1] ? -xe : xe;
    if (ax > MAXP) ax = MAXP;
    a_n = bus.in_mode ? (ax <<< 1) : ax;
    if (a_n > MAXP) a_n = MAXP;
  end

  // stage 1 register
  always_ff @(posedge clk) begin
    if (reset) begin
      s1 <= '0;
    end else if (advance) begin
      s1.v    <= bus.in_valid;
      s1.a    <= a_n;
      s1.neg  <= bus.in_x[DATA_W-1];
      s1.mode <= bus.in_mode;
      s1.tag  <= bus.in_tag;
    end
  end

  logic [8:1]          lt;
  logic signed [W-1:0] p_n;
  logic signed [W-1:0] b_n;

  // thermometer compare; lowest matching segment wins
  always_comb begin
    p_n = '0;
    b_n = '0;
    for (int i = 1; i <= 8; i++) begin
      lt[i] = s1.a < TH[i];
    end
    for (int i = 8; i >= 1; i--) begin
      if (lt[i]) begin
        p_n = s1.a >>> (i + 1);
        b_n = BS[i];
      end
    end
  end

  // stage 2 register
  always_ff @(posedge clk) begin
    if (reset) begin
      s2 <= '0;
    end else if (advance) begin
      s2.v    <= s1.v;
      s2.p    <= p_n;
      s2.b    <= b_n;
      s2.sat  <= !lt[8];
      s2.neg  <= s1.neg;
      s2.mode <= s1.mode;
      s2.tag  <= s1.tag;
    end
  end

  logic signed [W-1:0] y0;
  logic signed [W-1:0] y1;
  logic signed [W-1:0] y2;
  logic                unused_hi;

  // segment line, mirror for negatives, tanh rescale
  always_comb begin
    y0 = s2.sat ? ONE : s2.p + s2.b;
    y1 = s2.neg ? ONE - y0 : y0;
    y2 = s2.mode ? (y1 <<< 1) - ONE : y1;
  end

  assign unused_hi = ^y2[W-1:DATA_W];

  // output register
  always_ff @(posedge clk) begin
    if (reset) begin
      bus.out_valid <= 1'b0;
      bus.out_y     <= '0;
      bus.out_tag   <= '0;
      bus.out_sat   <= 1'b0;
    end else if (advance) begin
      bus.out_valid <= s2.v;
      if (s2.v) begin
        bus.out_y   <= y2[DATA_W-1:0];
        bus.out_tag <= s2.tag;
        bus.out_sat <= s2.sat;
      end
    end
  end
endmodule
